rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
Sequences the single write port of the 64-bit, 32-entry integer register file.
- Arbitrates write-back requests from two sources, ALU and load unit, onto the port.
- Keeps a pending-write scoreboard and stalls issue on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file write inputs (writereg, rd, writedata).

Parameters:
XLEN, 64, data width of register file entries
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
iss_valid  in  1  instruction attempting issue this cycle
iss_rs1  in  AW  source register 1 of issuing instruction
iss_rs2  in  AW  source register 2 of issuing instruction
iss_rd  in  AW  destination register of issuing instruction (0 = no write)
iss_stall  out  1  hazard: issue must not proceed this cycle
alu_valid  in  1  ALU write-back request
alu_rd  in  AW  ALU destination
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load write-back request
mem_rd  in  AW  load destination
mem_data  in  XLEN  load data
mem_ready  out  1  load request accepted this cycle
writereg  out  1  register file write enable (registered)
rd  out  AW  register file write address (registered)
writedata  out  XLEN  register file write data (registered)
busy  out  NREG  scoreboard vector, bit i = write to reg i pending

Behaviour:
- Clock and reset: one clock `clock`. Reset `reset` is asynchronous and active-high.
- Reset values: writereg=0, rd=0, writedata=0, busy=0, round-robin pointer=ALU.
- Reset mid-operation: pending hazards are cleared, and any request presented in the reset cycle is not accepted.
- Handshake: a transfer occurs when valid && ready.
  - ready is combinational from the valid signals and the arbiter state only.
  - At most one of alu_ready/mem_ready is high per cycle.
  - A source whose request is not accepted must hold rd/data stable until accepted.
- Arbitration (default): fixed priority, mem over alu. alu_ready = alu_valid && !mem_valid.
- Write-back latency: 1 cycle. On a granted transfer, at the next edge:
  - writereg <= (granted rd != 0); rd <= granted rd; writedata <= granted data.
  - With no grant: writereg <= 0, and rd/writedata hold their previous values.
- x0 handling:
  - A grant with rd=0 is accepted (ready high) but produces writereg=0.
  - busy[0] is constant 0.
- Scoreboard:
  - set: busy[iss_rd] <= 1 when iss_valid && !iss_stall && iss_rd != 0.
  - clear: busy[g_rd] <= 0 on a granted transfer with g_rd != 0.
  - Same register set and cleared in one cycle: set wins (a newer write is pending).
- Stall (combinational, registered busy only, no same-cycle bypass):
  - iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]), where reg 0 terms are 0.
  - The earliest unstall is the cycle in which writereg=1 for that register; the register file write completes at that cycle's edge.
- Write-back for a non-busy register: accepted normally. There is no error signalling.

Optional Feature:
Macro WB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - When both sources are valid, the source not granted last time wins.
  - The pointer updates only on a contested grant.
  - After reset, the ALU has priority on the first contest.
- Undefined: fixed priority mem over alu. The pointer register is not instantiated.

Decomposition:
- Package rf_ctrl_pkg: XLEN, NREG, AW constants; enum wb_src_e {SRC_ALU, SRC_MEM}; reg_addr_t typedef.
- Sub-module rf_scoreboard: busy vector with set/clear ports and two read ports plus the WAW port; produces the stall term.
- The arbiter and output register stay in rf_wb_scheduler.

Test Plan:
- Reset release, all valids 0 → writereg=0, rd=0, writedata=0, busy=0, iss_stall=0.
- Issue rd=5; next cycle issue rs1=5 → busy[5]=1, iss_stall=1. mem_valid, mem_rd=5, mem_data=64'hDEAD_BEEF → mem_ready=1; next cycle writereg=1, rd=5, writedata=64'hDEAD_BEEF, busy[5]=0, iss_stall=0.
- alu_valid and mem_valid both high (rd=3 and rd=4) for 2 cycles → cycle 1 mem granted, cycle 2 alu granted; writes to 4 then 3.
  - With WB_ROUND_ROBIN_EN: alu first, then mem.
- alu_valid with alu_rd=0, alu_data=64'h1 → alu_ready=1, writereg stays 0, busy unchanged.
- Issue rd=7 while a grant for rd=7 occurs in the same cycle → busy[7]=1 afterwards. A second write-back to rd=7 clears it.
- Set busy[9], assert reset asynchronously mid-cycle with mem_valid high → busy=0 and writereg=0 immediately; no write to reg 9 after reset deasserts.

Source files
------------

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package rf_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Issue, write-back request and register-file write signals of the scheduler.
// master: the execute/memory side driving requests; slave: the scheduler.
interface rf_wb_scheduler_if;
    import rf_ctrl_pkg::*;

    logic             iss_valid;
    reg_addr_t        iss_rs1;
    reg_addr_t        iss_rs2;
    reg_addr_t        iss_rd;
    logic             iss_stall;
    logic             alu_valid;
    reg_addr_t        alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             alu_ready;
    logic             mem_valid;
    reg_addr_t        mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             mem_ready;
    logic             writereg;
    reg_addr_t        rd;
    logic [XLEN-1:0]  writedata;
    logic [NREG-1:0]  busy;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  iss_stall, alu_ready, mem_ready,
        input  writereg, rd, writedata, busy
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output iss_stall, alu_ready, mem_ready,
        output writereg, rd, writedata, busy
    );

endinterface

// File: rtl/rf_wb_scheduler_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
// Produces the issue stall term from the registered busy vector only.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            set_en,
    input  reg_addr_t       set_addr,
    input  logic            clr_en,
    input  reg_addr_t       clr_addr,
    input  logic            chk_en,
    input  reg_addr_t       rs1,
    input  reg_addr_t       rs2,
    input  reg_addr_t       waw_rd,
    output logic [NREG-1:0] busy,
    output logic            stall
);

    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_next;

    assign busy = {busy_q, 1'b0};

    // Clear first, then set, so a newer pending write survives a same-cycle retire.
    always_comb begin
        busy_next = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (clr_en && clr_addr == reg_addr_t'(i)) busy_next[i] = 1'b0;
            if (set_en && set_addr == reg_addr_t'(i)) busy_next[i] = 1'b1;
        end
    end

    // Busy vector state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_next;
    end

    assign stall = chk_en && (busy[rs1] || busy[rs2] || busy[waw_rd]);

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU and load write-backs onto
// the single write port and stalls issue on RAW/WAW hazards.
// Build option: WB_ROUND_ROBIN_EN selects round-robin arbitration between the
// two sources; otherwise loads always win over the ALU.
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    rf_wb_scheduler_if.slave bus
);

    logic            alu_gnt;
    logic            mem_gnt;
    logic            gnt;
    wb_src_e         gnt_src;
    reg_addr_t       g_rd;
    logic [XLEN-1:0] g_data;
    logic            stall;

`ifdef WB_ROUND_ROBIN_EN
    wb_src_e prio;
    logic    contest;

    // Contested requests go to the source that lost the previous contest.
    always_comb begin
        contest = bus.alu_valid && bus.mem_valid;
        if (contest) begin
            mem_gnt = (prio == SRC_MEM) && !reset;
            alu_gnt = (prio == SRC_ALU) && !reset;
        end else begin
            mem_gnt = bus.mem_valid && !reset;
            alu_gnt = bus.alu_valid && !reset;
        end
    end

    // Priority pointer only moves when both sources competed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        prio <= SRC_ALU;
        else if (contest) prio <= alu_gnt ? SRC_MEM : SRC_ALU;
    end
`else
    // Fixed priority: loads over ALU; nothing is accepted while in reset.
    always_comb begin
        mem_gnt = bus.mem_valid && !reset;
        alu_gnt = bus.alu_valid && !bus.mem_valid && !reset;
    end
`endif

    assign bus.mem_ready = mem_gnt;
    assign bus.alu_ready = alu_gnt;
    assign gnt           = alu_gnt || mem_gnt;
    assign gnt_src       = mem_gnt ? SRC_MEM : SRC_ALU;
    assign g_rd          = (gnt_src == SRC_MEM) ? bus.mem_rd   : bus.alu_rd;
    assign g_data        = (gnt_src == SRC_MEM) ? bus.mem_data : bus.alu_data;

    // Register-file write port; address/data hold when nothing is granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.writereg  <= 1'b0;
            bus.rd        <= '0;
            bus.writedata <= '0;
        end else begin
            bus.writereg <= gnt && (g_rd != '0);
            if (gnt) begin
                bus.rd        <= g_rd;
                bus.writedata <= g_data;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (bus.iss_valid && !stall),
        .set_addr (bus.iss_rd),
        .clr_en   (gnt),
        .clr_addr (g_rd),
        .chk_en   (bus.iss_valid),
        .rs1      (bus.iss_rs1),
        .rs2      (bus.iss_rs2),
        .waw_rd   (bus.iss_rd),
        .busy     (bus.busy),
        .stall    (stall)
    );

    assign bus.iss_stall = stall;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler. Expected register-file writes are queued
// by the stimulus; a negedge monitor pops and compares each observed write.
module tb_rf_wb_scheduler;
    import rf_ctrl_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    logic clock;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    wb_t  exp_q[$];
    logic mdl_mem_pri = 1'b0;

    rf_wb_scheduler_if bus ();

    rf_wb_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [63:0] d);
        wb_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every observed register-file write must match the next expected one.
    initial begin
        wb_t e;
        forever begin
            @(negedge clock);
            if (bus.writereg === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wb_unexpected: got write rd=%0d data=%h, required no write",
                             bus.rd, bus.writedata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", 64'(bus.rd), 64'(e.rd));
                    chk("wb_data", bus.writedata, e.data);
                end
            end
        end
    end

    // Both sources valid; winner drops after its grant, loser follows next cycle.
    task automatic contest(input logic [4:0] a_rd, input logic [63:0] a_d,
                           input logic [4:0] m_rd, input logic [63:0] m_d);
        logic mem_first;
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = a_rd; bus.alu_data = a_d;
        bus.mem_valid = 1'b1; bus.mem_rd = m_rd; bus.mem_data = m_d;
        #1;
`ifdef WB_ROUND_ROBIN_EN
        mem_first   = mdl_mem_pri;
        mdl_mem_pri = !mem_first;
`else
        mem_first = 1'b1;
`endif
        chk("contest_mem_ready", 64'(bus.mem_ready), 64'(mem_first));
        chk("contest_alu_ready", 64'(bus.alu_ready), 64'(!mem_first));
        if (mem_first) push(m_rd, m_d); else push(a_rd, a_d);
        tick();
        if (mem_first) bus.mem_valid = 1'b0; else bus.alu_valid = 1'b0;
        #1;
        if (mem_first) begin
            chk("loser_alu_ready", 64'(bus.alu_ready), 64'd1);
            push(a_rd, a_d);
        end else begin
            chk("loser_mem_ready", 64'(bus.mem_ready), 64'd1);
            push(m_rd, m_d);
        end
        tick();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0;
        bus.alu_valid = 1'b0; bus.alu_rd  = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd  = '0; bus.mem_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        tick();
        chk("rst_writereg", 64'(bus.writereg), 64'd0);
        chk("rst_rd", 64'(bus.rd), 64'd0);
        chk("rst_writedata", bus.writedata, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_stall", 64'(bus.iss_stall), 64'd0);

        // RAW hazard on r5 resolved by a load write-back
        tick();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        #1;
        chk("iss5_stall", 64'(bus.iss_stall), 64'd0);
        tick();
        bus.iss_rs1 = 5'd5; bus.iss_rd = 5'd0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 64'hDEAD_BEEF;
        #1;
        chk("raw_busy", 64'(bus.busy), 64'h20);
        chk("raw_stall", 64'(bus.iss_stall), 64'd1);
        chk("raw_mem_ready", 64'(bus.mem_ready), 64'd1);
        chk("raw_alu_ready", 64'(bus.alu_ready), 64'd0);
        push(5'd5, 64'hDEAD_BEEF);
        tick();
        bus.mem_valid = 1'b0;
        #1;
        chk("wb5_writereg", 64'(bus.writereg), 64'd1);
        chk("wb5_rd", 64'(bus.rd), 64'd5);
        chk("wb5_busy", 64'(bus.busy), 64'd0);
        chk("wb5_stall", 64'(bus.iss_stall), 64'd0);
        bus.iss_valid = 1'b0; bus.iss_rs1 = '0;

        // Arbitration contests
        contest(5'd3, 64'h33, 5'd4, 64'h44);
        contest(5'd10, 64'hA0A0, 5'd11, 64'hB1B1);
        contest(5'd12, 64'h1212, 5'd13, 64'h1313);

        // Write-back to x0 is accepted but never writes
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 64'h1;
        #1;
        chk("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick();
        bus.alu_valid = 1'b0;
        #1;
        chk("x0_writereg", 64'(bus.writereg), 64'd0);
        chk("x0_busy", 64'(bus.busy), 64'd0);

        // Same-cycle set and clear of r7: set wins
        tick();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h77;
        #1;
        chk("waw7_stall", 64'(bus.iss_stall), 64'd0);
        chk("waw7_alu_ready", 64'(bus.alu_ready), 64'd1);
        push(5'd7, 64'h77);
        tick();
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.alu_data = 64'h78;
        #1;
        chk("waw7_busy_set", 64'(bus.busy), 64'h80);
        push(5'd7, 64'h78);
        tick();
        bus.alu_valid = 1'b0;
        #1;
        chk("waw7_busy_clr", 64'(bus.busy), 64'd0);

        // Asynchronous reset mid-cycle with a pending r9 and a live load request
        tick();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 64'h20;
        push(5'd20, 64'h20);
        #1;
        chk("iss9_stall", 64'(bus.iss_stall), 64'd0);
        tick();
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.alu_valid = 1'b0;
        #1;
        chk("pre_rst_busy", 64'(bus.busy), 64'h200);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 64'h99;
        #1;
        chk("pre_rst_mem_ready", 64'(bus.mem_ready), 64'd1);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_writereg", 64'(bus.writereg), 64'd0);
        chk("mid_rst_rd", 64'(bus.rd), 64'd0);
        chk("mid_rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus.mem_valid = 1'b0;
        mdl_mem_pri = 1'b0;
        tick();
        chk("post_rst_writereg", 64'(bus.writereg), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        // Arbitration pointer restarts from reset value
        contest(5'd21, 64'h2121, 5'd22, 64'h2222);

        repeat (3) tick();
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
